// File: rtl/kalman_axis_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : kalman_axis_scheduler
// Purpose  : Shares one Kalman forecast/update engine pair between the roll
//            (ch=0) and pitch (ch=1) axes. Keeps per-axis filter state
//            {angle, bias, P00, P01, P10, P11} in a two-entry bank, runs
//            forecast then update for each axis per gyro sample and writes
//            the update result back. Includes a one-deep sample buffer with
//            overrun pulse and an engine-done watchdog.
// Ports    :
//   clk_in, rst_n                 clock, asynchronous active-low reset
//   sample_vld_in                 strobe: roll/pitch/gyro inputs valid
//   roll_in, pitch_in             measured angles (Q16.16)
//   gyro_x_in, gyro_y_in          gyro rates (Q16.16)
//   gyro_x_bias_in, gyro_y_bias_in  signed 16-bit rate offsets
//   calib_done_pos_in             strobe: reinitialise all state
//   forecast_en_out / _done_in    forecast engine start / completion
//   update_en_out / _done_in      update engine start / completion
//   gyro_out, new_angle_out       corrected rate / measured angle, axis ch
//   state_t_1_out                 bank contents of axis ch
//   state_in                      state returned by the update engine
//   angle_opt_out                 latest filtered angle
//   roll_opt_vld_out, pitch_opt_vld_out  one-cycle qualifiers
//   overrun_out                   pulse: buffered sample overwritten
//   timeout_err_out               sticky engine timeout flag
//   busy_out                      FSM not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module kalman_axis_scheduler #(
    parameter logic [31:0] P_INIT_DIAG = 32'd65536,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         sample_vld_in,
    input  logic [31:0]  roll_in,
    input  logic [31:0]  pitch_in,
    input  logic [31:0]  gyro_x_in,
    input  logic [31:0]  gyro_y_in,
    input  logic [15:0]  gyro_x_bias_in,
    input  logic [15:0]  gyro_y_bias_in,
    input  logic         calib_done_pos_in,
    output logic         forecast_en_out,
    input  logic         forecast_done_in,
    output logic         update_en_out,
    input  logic         update_done_in,
    output logic [31:0]  gyro_out,
    output logic [31:0]  new_angle_out,
    output logic [191:0] state_t_1_out,
    input  logic [191:0] state_in,
    output logic [31:0]  angle_opt_out,
    output logic         roll_opt_vld_out,
    output logic         pitch_opt_vld_out,
    output logic         overrun_out,
    output logic         timeout_err_out,
    output logic         busy_out
);

    localparam int WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] c_WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [191:0] c_BANK_INIT =
        {32'd0, 32'd0, P_INIT_DIAG, 32'd0, 32'd0, P_INIT_DIAG};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE_F = 3'd1,
        S_WAIT_F  = 3'd2,
        S_ISSUE_U = 3'd3,
        S_WAIT_U  = 3'd4
    } state_t;

    state_t         r_state, w_state_nxt;
    logic           r_ch, w_ch_nxt;
    logic [WD_W-1:0] r_wd, w_wd_nxt;

    logic           w_start, w_use_pend, w_wb, w_timeout, w_advance, w_overrun;

    // Working sample (the one being filtered) and the one-deep buffer
    logic [31:0]    r_roll, r_pitch, r_gx, r_gy;
    logic           r_pend_vld;
    logic [31:0]    r_pend_roll, r_pend_pitch, r_pend_gx, r_pend_gy;

    logic [191:0]   r_bank_roll, r_bank_pitch;

    logic           r_fen, r_uen, r_busy, r_roll_vld, r_pitch_vld, r_overrun, r_terr;
    logic [31:0]    r_gyro, r_new_angle, r_angle_opt;
    logic [191:0]   r_state_t_1;

    // Bias correction: plain 32-bit wrap, no saturation
    logic [31:0] w_live_gx, w_live_gy;
    assign w_live_gx = gyro_x_in - {{16{gyro_x_bias_in[15]}}, gyro_x_bias_in};
    assign w_live_gy = gyro_y_in - {{16{gyro_y_bias_in[15]}}, gyro_y_bias_in};

    logic [31:0] w_cap_roll, w_cap_pitch, w_cap_gx, w_cap_gy;
    assign w_cap_roll  = w_use_pend ? r_pend_roll  : roll_in;
    assign w_cap_pitch = w_use_pend ? r_pend_pitch : pitch_in;
    assign w_cap_gx    = w_use_pend ? r_pend_gx    : w_live_gx;
    assign w_cap_gy    = w_use_pend ? r_pend_gy    : w_live_gy;

    // On the start edge the working registers are still loading, so the
    // ISSUE_F outputs must be taken from the capture path directly.
    logic [31:0] w_src_roll, w_src_pitch, w_src_gx, w_src_gy;
    assign w_src_roll  = w_start ? w_cap_roll  : r_roll;
    assign w_src_pitch = w_start ? w_cap_pitch : r_pitch;
    assign w_src_gx    = w_start ? w_cap_gx    : r_gx;
    assign w_src_gy    = w_start ? w_cap_gy    : r_gy;

    // A live sample is buffered whenever the FSM is not idle
    assign w_overrun = sample_vld_in && (r_state != S_IDLE) && r_pend_vld
                       && !calib_done_pos_in;

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_wd_nxt    = r_wd;
        w_start     = 1'b0;
        w_use_pend  = 1'b0;
        w_wb        = 1'b0;
        w_timeout   = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_vld) begin
                    w_start    = 1'b1;
                    w_use_pend = 1'b1;
                end else if (sample_vld_in) begin
                    w_start    = 1'b1;
                end
                if (w_start) begin
                    w_ch_nxt    = 1'b0;
                    w_state_nxt = S_ISSUE_F;
                end
            end
            S_ISSUE_F: begin
                w_state_nxt = S_WAIT_F;
                w_wd_nxt    = '0;
            end
            S_WAIT_F: begin
                if (forecast_done_in) begin
                    w_state_nxt = S_ISSUE_U;
                end else if (r_wd == c_WD_LAST) begin
                    w_timeout = 1'b1;
                    w_advance = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + WD_W'(1);
                end
            end
            S_ISSUE_U: begin
                w_state_nxt = S_WAIT_U;
                w_wd_nxt    = '0;
            end
            S_WAIT_U: begin
                if (update_done_in) begin
                    w_wb      = 1'b1;
                    w_advance = 1'b1;
                end else if (r_wd == c_WD_LAST) begin
                    w_timeout = 1'b1;
                    w_advance = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + WD_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Completion or timeout both move on to the next axis
        if (w_advance) begin
            if (!r_ch) begin
                w_ch_nxt    = 1'b1;
                w_state_nxt = S_ISSUE_F;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end

        // Calibration overrides everything, including a same-cycle done
        if (calib_done_pos_in) begin
            w_state_nxt = S_IDLE;
            w_ch_nxt    = 1'b0;
            w_wd_nxt    = '0;
            w_start     = 1'b0;
            w_use_pend  = 1'b0;
            w_wb        = 1'b0;
            w_timeout   = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ch         <= 1'b0;
            r_wd         <= '0;
            r_roll       <= '0;
            r_pitch      <= '0;
            r_gx         <= '0;
            r_gy         <= '0;
            r_pend_vld   <= 1'b0;
            r_pend_roll  <= '0;
            r_pend_pitch <= '0;
            r_pend_gx    <= '0;
            r_pend_gy    <= '0;
            r_bank_roll  <= c_BANK_INIT;
            r_bank_pitch <= c_BANK_INIT;
            r_fen        <= 1'b0;
            r_uen        <= 1'b0;
            r_busy       <= 1'b0;
            r_roll_vld   <= 1'b0;
            r_pitch_vld  <= 1'b0;
            r_overrun    <= 1'b0;
            r_terr       <= 1'b0;
            r_gyro       <= '0;
            r_new_angle  <= '0;
            r_angle_opt  <= '0;
            r_state_t_1  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ch        <= w_ch_nxt;
            r_wd        <= w_wd_nxt;
            r_fen       <= (w_state_nxt == S_ISSUE_F);
            r_uen       <= (w_state_nxt == S_ISSUE_U);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_roll_vld  <= w_wb && !r_ch;
            r_pitch_vld <= w_wb && r_ch;
            r_overrun   <= w_overrun;

            if (w_start) begin
                r_roll  <= w_cap_roll;
                r_pitch <= w_cap_pitch;
                r_gx    <= w_cap_gx;
                r_gy    <= w_cap_gy;
            end

            if (w_state_nxt == S_ISSUE_F) begin
                r_gyro      <= w_ch_nxt ? w_src_gy    : w_src_gx;
                r_new_angle <= w_ch_nxt ? w_src_pitch : w_src_roll;
                r_state_t_1 <= w_ch_nxt ? r_bank_pitch : r_bank_roll;
            end

            if (w_wb) begin
                if (r_ch) r_bank_pitch <= state_in;
                else      r_bank_roll  <= state_in;
                r_angle_opt <= state_in[191:160];
            end

            // Buffer: consuming and refilling in the same cycle is not an overrun
            if (w_use_pend) begin
                r_pend_vld <= sample_vld_in;
            end else if (sample_vld_in && (r_state != S_IDLE)) begin
                r_pend_vld <= 1'b1;
            end
            if (sample_vld_in && (w_use_pend || (r_state != S_IDLE))) begin
                r_pend_roll  <= roll_in;
                r_pend_pitch <= pitch_in;
                r_pend_gx    <= w_live_gx;
                r_pend_gy    <= w_live_gy;
            end

            if (w_timeout) r_terr <= 1'b1;

            if (calib_done_pos_in) begin
                r_pend_vld   <= 1'b0;
                r_bank_roll  <= c_BANK_INIT;
                r_bank_pitch <= c_BANK_INIT;
                r_terr       <= 1'b0;
                r_gyro       <= '0;
                r_new_angle  <= '0;
                r_angle_opt  <= '0;
                r_state_t_1  <= '0;
            end
        end
    end

    assign forecast_en_out   = r_fen;
    assign update_en_out     = r_uen;
    assign busy_out          = r_busy;
    assign roll_opt_vld_out  = r_roll_vld;
    assign pitch_opt_vld_out = r_pitch_vld;
    assign overrun_out       = r_overrun;
    assign timeout_err_out   = r_terr;
    assign gyro_out          = r_gyro;
    assign new_angle_out     = r_new_angle;
    assign angle_opt_out     = r_angle_opt;
    assign state_t_1_out     = r_state_t_1;

endmodule
`default_nettype wire

// File: doc/kalman_axis_scheduler.md
# kalman_axis_scheduler

Time-multiplexes one Kalman forecast/update engine pair between the roll and pitch axes. Holds per-axis filter state (angle, bias, 2x2 P matrix) in an internal bank, sequences forecast then update for each axis per gyro sample, and writes the results back to the bank. Sits between the fixed-point sensor front end and the shared forecast/update engines. Adds a one-deep sample buffer, an overrun flag and an engine watchdog.

## Interface
- P_INIT_DIAG, 32'd65536: reset/calib value of P_0_0 and P_1_1, Q16.16; P_0_1 and P_1_0 are initialised to 0.
- TIMEOUT_CYC, 'd64: maximum number of cycles to wait for an engine done.
- clk_in in 1: clock; single clock domain.
- rst_n in 1: asynchronous, active-low reset.
- sample_vld_in in 1: one-cycle strobe; roll/pitch/gyro inputs are valid.
- roll_in, pitch_in, gyro_x_in, gyro_y_in in 32 each: signed Q16.16 measurements.
- gyro_x_bias_in, gyro_y_bias_in in 16 each: signed calibration offsets.
- calib_done_pos_in in 1: one-cycle strobe; reinitialise everything.
- forecast_en_out out 1: one-cycle start strobe to the forecast engine.
- forecast_done_in in 1: forecast engine completion strobe.
- update_en_out out 1: one-cycle start strobe to the update engine.
- update_done_in in 1: update engine completion strobe.
- gyro_out out 32: bias-corrected rate for the current axis.
- new_angle_out out 32: measured angle for the current axis.
- state_t_1_out out 192: {angle, bias, P_0_0, P_0_1, P_1_0, P_1_1} of the current axis, read from the bank.
- state_in in 192: the same packing, returned by the update engine.
- angle_opt_out out 32: latest filtered angle.
- roll_opt_vld_out, pitch_opt_vld_out out 1: one-cycle qualifiers for angle_opt_out.
- overrun_out out 1: one-cycle pulse; a buffered sample was overwritten.
- timeout_err_out out 1: sticky engine-timeout flag.
- busy_out out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE_F, WAIT_F, ISSUE_U, WAIT_U. Axis index ch: 0 = roll, 1 = pitch.
- IDLE behaviour:
  - If the pending buffer is valid, consume it.
  - Else, if sample_vld_in is high, capture the live inputs.
  - Either case sets ch=0 and moves to ISSUE_F.
  - Pending has priority over a simultaneous live sample; that live sample goes into pending.
- Capture: the working registers latch the roll, pitch and gyro values. gyro_x_c = gyro_x_in − sign-extended gyro_x_bias_in, 32-bit two's-complement wrap, no saturation. gyro_y_c is formed the same way.
- ISSUE_F:
  - forecast_en_out=1 for this cycle only.
  - gyro_out, new_angle_out and state_t_1_out present axis ch.
  - These outputs stay stable until the next ISSUE_F or calib.
  - Next state is WAIT_F.
- WAIT_F: on forecast_done_in, go to ISSUE_U.
- ISSUE_U: update_en_out=1 for one cycle, then go to WAIT_U.
- WAIT_U, on update_done_in:
  - bank[ch] <= state_in.
  - angle_opt_out <= state_in[191:160].
  - Set the vld of axis ch for the next cycle.
  - If ch=0, set ch=1 and go to ISSUE_F; otherwise go to IDLE.
- Done strobes are ignored in any state other than the matching WAIT state.
- Watchdog (only counts in WAIT_F/WAIT_U):
  - Counter clears on entry to either WAIT state.
  - If it reaches TIMEOUT_CYC with no done: bank[ch] is unchanged, no vld, timeout_err_out is set.
  - The FSM then proceeds as if update had completed: move to the next axis, or to IDLE.
- Samples arriving while busy_out=1 are stored in the pending buffer. If pending is already full, it is overwritten with the newer sample and overrun_out pulses.
- calib_done_pos_in (highest priority, effective the cycle after it is sampled):
  - FSM goes to IDLE.
  - Banks reset to angle=0, bias=0 and P_INIT values.
  - Pending is cleared and timeout_err_out is cleared.
  - Any in-flight done strobe is ignored.
  - A sample_vld_in in the same cycle is dropped.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE, ch=0, pending empty.
  - Banks hold angle 0, bias 0, P_0_0 = P_1_1 = P_INIT_DIAG, P_0_1 = P_1_0 = 0.
- All outputs are registered. There are no combinational input-to-output paths.
- With the sample sampled at cycle 0: forecast_en_out is high at cycle 1. For engine latencies Lf and Lu (done Lf cycles after the enable): update_en_out is high at 2+Lf and roll_opt_vld_out at 3+Lf+Lu. The pitch ISSUE_F falls in the same cycle as roll_opt_vld_out.
- Back-to-back: a sample buffered during pitch processing starts in the cycle after the FSM re-enters IDLE.
- Reset asserted mid-operation: all state is lost immediately. No partial writeback to the bank.

## Test plan
- Engine model with done 3 cycles after each enable; sample at cycle 0 -> forecast_en at 1, update_en at 5, roll_opt_vld at 9, pitch forecast_en at 9, pitch_opt_vld at 17, busy_out drops at 17.
- gyro_x_in=32'h0001_0000, gyro_x_bias_in=16'h8000 -> gyro_out=32'h0001_8000 during the roll ISSUE_F.
- Two samples during one iteration -> the second is processed; overrun_out pulses exactly once, on the third sample.
- Engine never asserts forecast_done with TIMEOUT_CYC=8 -> no roll vld, timeout_err_out=1, pitch ISSUE_F follows, roll bank unchanged.
- calib_done_pos_in during WAIT_U with a simultaneous update_done_in -> no vld, bank P_0_0 reads P_INIT_DIAG on the next iteration, timeout_err_out cleared.
- Assert rst_n low during WAIT_F -> all outputs 0 asynchronously; the first sample after release behaves as in the first scenario.
